maxpool_stream: RTL and testbench
=================================

Name: maxpool_stream

Overview:
- Streaming 1-D max-pool stage directly downstream of the convolution block.
- Consumes the convolution output vector of LENY signed samples over a valid/ready handshake and reduces each non-overlapping window of WIN samples to its signed maximum.
- Emits the pooled vector over a valid/ready handshake, with a last-of-vector flag.
- A 2-entry output FIFO decouples downstream backpressure from the input side.

Parameters:
- WIDTH, 8, sample width in bits, signed two's complement.
- LENY, 5, input samples per vector; equals the convolution output length.
- WIN, 2, pooling window length and stride; non-overlapping windows; must be >= 1.
- NOUT, ceil(LENY/WIN), pooled outputs per vector; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock; only clock.
- reset  in  1  synchronous, active-low reset; asserted when 0, sampled on the clk rising edge.
- s_data_in_y  in  WIDTH  input sample, signed.
- s_valid_y  in  1  input sample valid.
- s_ready_y  out  1  block can accept the input sample.
- m_data_out_z  out  WIDTH  pooled sample, signed.
- m_valid_z  out  1  pooled sample valid.
- m_ready_z  in  1  downstream accepts the pooled sample.
- m_last_z  out  1  pooled sample is the last (NOUT-th) of its vector; qualified by m_valid_z.

Behaviour:
- Input transfer: s_valid_y && s_ready_y on a clk edge. Output transfer: m_valid_z && m_ready_z on a clk edge.
- Reset (reset==0): in_cnt=0, win_cnt=0, run_max=0, FIFO emptied. Outputs: m_valid_z=0, m_data_out_z=0, m_last_z=0, s_ready_y=0.
- Reset mid-vector: the partial window and any queued outputs are discarded; no output is produced for them.
- in_cnt counts 0..LENY-1 within the vector. win_cnt counts 0..WIN-1 within the window.
- Closing beat: an accepted sample with win_cnt==WIN-1 or in_cnt==LENY-1.
  - Ceil mode: a trailing partial window closes at the end of the vector and is emitted.
- Running max:
  - First beat of a window (win_cnt==0) loads the sample directly into run_max.
  - Later beats set run_max = max(run_max, sample), using a signed compare.
  - Ties keep the value; no saturation or width growth.
- Closing beat actions:
  - Push max(run_max, sample), or the sample itself if win_cnt==0, into the FIFO.
  - Tag it last = (in_cnt==LENY-1).
  - Reset win_cnt to 0. If last, also reset in_cnt to 0.
- Back-to-back vectors: the first sample after a last beat starts a new vector with no idle cycle.
- s_ready_y = reset && (!fifo_full || !closing_beat_pending).
  - closing_beat_pending is decoded from the counters only.
  - Non-closing samples are accepted even when the FIFO is full.
  - No combinational path from m_ready_z to s_ready_y: a pop and a closing push in the same cycle when full is not allowed; input stalls one cycle.
- FIFO: depth 2, registered head.
  - Push while not full; pop on an output transfer.
  - Simultaneous push and pop with count==1: count stays 1, head advances to the pushed entry.
  - Simultaneous push and pop with count==2: cannot occur, excluded by s_ready_y.
- m_valid_z = FIFO non-empty. m_data_out_z and m_last_z = head entry. Head is 0/0 when empty.
- Latency: closing beat accepted at edge t → m_valid_z=1 after edge t, when the FIFO was empty. Throughput is 1 output/cycle.
- m_data_out_z and m_last_z are stable while m_valid_z && !m_ready_z.

Decomposition:
- Package maxpool_pkg holds:
  - WIDTH, LENY and WIN defaults;
  - function ceil_div for NOUT;
  - counter width constants $clog2(LENY) and $clog2(WIN)+1;
  - typedef sample_t (logic signed [WIDTH-1:0]);
  - typedef struct {sample_t data; logic last;} pool_entry_t.
- One sub-module: pool_out_fifo, a 2-entry FIFO of pool_entry_t with push/pop/full/empty/count.
- Counters, running max and ready logic stay in maxpool_stream.

Test Plan:
- Basic, LENY=5 WIN=2, m_ready_z=1: input 3,7,-1,4,9 back-to-back → outputs 7,4,9; m_last_z=1 only on 9; each output 1 cycle after its closing beat.
- All-negative / ties: input -5,-3,-8,-8,-128 → outputs -3,-8,-128; signed compare verified.
- Backpressure: m_ready_z=0, s_valid_y=1 with input 1,2,3,4,5:
  - Outputs 2 and 4 queue.
  - s_ready_y=0 when 5 arrives (closing, FIFO full); 1 and 3 were still accepted.
  - m_ready_z raised → outputs 2,4,5, with 5 tagged last.
- Two vectors back-to-back with random s_valid_y gaps and m_ready_z toggling: 10 inputs → 6 outputs, last on outputs 3 and 6, values match the reference model.
- Reset mid-vector: after inputs 6,2,9, assert reset=0 for 1 cycle → m_valid_z=0, FIFO empty. Then new vector 1,1,1,1,1 → outputs 1,1,1, last on the third.
- WIN=1 variant: output equals input sample-for-sample, last on every LENY-th output.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared definitions for the streaming 1-D max-pool stage.
// Holds parameter defaults, the ceil_div helper used for the pooled length, counter-width
// helpers, and the sample / FIFO entry types.
package maxpool_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefLeny  = 5;
    localparam int unsigned DefWin   = 2;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    // Width of the in-vector sample counter; never narrower than one bit.
    function automatic int unsigned in_cnt_w(input int unsigned leny);
        return (leny > 1) ? $clog2(leny) : 1;
    endfunction

    // Width of the in-window counter.
    function automatic int unsigned win_cnt_w(input int unsigned win);
        return $clog2(win) + 1;
    endfunction

    localparam int unsigned DefNout    = ceil_div(DefLeny, DefWin);
    localparam int unsigned InCntWidth = in_cnt_w(DefLeny);
    localparam int unsigned WinCntWidth = win_cnt_w(DefWin);

    typedef logic signed [DefWidth-1:0] sample_t;

    typedef struct packed {
        sample_t data;
        logic    last;
    } pool_entry_t;

endpackage

// File: rtl/pool_out_fifo.sv
// Two-entry FIFO of pooled results with a registered head.
// Ports:
//   clk_i        clock
//   srst_ni      synchronous active-low reset (empties the FIFO, head reads 0)
//   push_i       write push_data_i (ignored when full)
//   push_data_i  entry to write
//   pop_i        drop the head entry (ignored when empty)
//   head_o       oldest entry; all zero when empty
//   full_o       two entries held
//   empty_o      no entries held
//   count_o      number of entries held (0..2)
module pool_out_fifo
    import maxpool_pkg::*;
#(
    parameter type entry_t = pool_entry_t
) (
    input  logic       clk_i,
    input  logic       srst_ni,
    input  logic       push_i,
    input  entry_t     push_data_i,
    input  logic       pop_i,
    output entry_t     head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign head_o  = head_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                // Head is cleared to zero once the last entry leaves.
                head_d  = (count_q == 2'd2) ? tail_q : '0;
                tail_d  = '0;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end else begin
                    head_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool: reduces each non-overlapping WIN-sample window of a LENY-sample
// signed vector to its maximum; a trailing partial window is closed at the end of the vector.
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-low reset
//   s_data_in_y   input sample (signed), s_valid_y / s_ready_y handshake
//   m_data_out_z  pooled sample (signed), m_valid_z / m_ready_z handshake
//   m_last_z      pooled sample is the last of its vector
module maxpool_stream
    import maxpool_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned LENY  = DefLeny,
    parameter int unsigned WIN   = DefWin
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_y,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    output logic signed [WIDTH-1:0] m_data_out_z,
    output logic                    m_valid_z,
    input  logic                    m_ready_z,
    output logic                    m_last_z
);

    typedef logic signed [WIDTH-1:0] smp_t;
    typedef struct packed {
        smp_t data;
        logic last;
    } entry_t;

    localparam int unsigned InW  = in_cnt_w(LENY);
    localparam int unsigned WinW = win_cnt_w(WIN);
    localparam logic [InW-1:0]  InLast  = InW'(LENY - 1);
    localparam logic [WinW-1:0] WinLast = WinW'(WIN - 1);

    logic [InW-1:0]  in_cnt_q, in_cnt_d;
    logic [WinW-1:0] win_cnt_q, win_cnt_d;
    smp_t            run_max_q, run_max_d;
    smp_t            cand;
    logic            vec_last, closing, accept;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]      fifo_count;
    entry_t          push_entry, head;

    assign vec_last = (in_cnt_q == InLast);
    // Whether the next accepted sample closes a window depends only on the counters.
    assign closing  = vec_last || (win_cnt_q == WinLast);

    // No path from m_ready_z: a closing sample waits a cycle if the FIFO is full.
    assign s_ready_y = reset && (!fifo_full || !closing);
    assign accept    = s_valid_y && s_ready_y;

    assign cand = ((win_cnt_q == '0) || (s_data_in_y > run_max_q)) ? s_data_in_y : run_max_q;

    assign fifo_push  = accept && closing;
    assign push_entry = '{data: cand, last: vec_last};
    assign fifo_pop   = m_valid_z && m_ready_z;

    always_comb begin
        in_cnt_d  = in_cnt_q;
        win_cnt_d = win_cnt_q;
        run_max_d = run_max_q;
        if (accept) begin
            run_max_d = cand;
            if (closing) begin
                win_cnt_d = '0;
                in_cnt_d  = vec_last ? '0 : in_cnt_q + 1'b1;
            end else begin
                win_cnt_d = win_cnt_q + 1'b1;
                in_cnt_d  = in_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_cnt_q  <= '0;
            win_cnt_q <= '0;
            run_max_q <= '0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            win_cnt_q <= win_cnt_d;
            run_max_q <= run_max_d;
        end
    end

    pool_out_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i       (clk),
        .srst_ni     (reset),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign m_valid_z    = !fifo_empty;
    assign m_data_out_z = head.data;
    assign m_last_z     = head.last;

    push_never_lost: assert property (@(posedge clk) disable iff (!reset)
        !(fifo_push && fifo_count == 2'd2));

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: scoreboard of expected pooled outputs filled by the
// driver's reference model, drained by an output monitor.
module tb_maxpool_stream;

    localparam int L = 5;
    localparam int N = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [7:0] s_data, m_data, s_data1, m_data1;
    logic              s_valid, s_ready, m_valid, m_ready, m_last;
    logic              s_valid1, s_ready1, m_valid1, m_ready1, m_last1;

    always #5 clk = ~clk;

    maxpool_stream #(.WIDTH(8), .LENY(L), .WIN(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data),
        .s_valid_y    (s_valid),
        .s_ready_y    (s_ready),
        .m_data_out_z (m_data),
        .m_valid_z    (m_valid),
        .m_ready_z    (m_ready),
        .m_last_z     (m_last)
    );

    maxpool_stream #(.WIDTH(8), .LENY(L), .WIN(1)) dut_w1 (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data1),
        .s_valid_y    (s_valid1),
        .s_ready_y    (s_ready1),
        .m_data_out_z (m_data1),
        .m_valid_z    (m_valid1),
        .m_ready_z    (m_ready1),
        .m_last_z     (m_last1)
    );

    typedef struct {
        int data;
        bit last;
        int cyc;
        bit lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0, n_fail = 0, cyc = 0, n_out = 0, n_last = 0;
    int   m_in = 0, m_win = 0, m_rm = 0;
    bit   lat_en = 0, tog_en = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model, stepped once per accepted input sample.
    task automatic model_accept(input int x);
        bit   close;
        exp_t e;
        m_rm  = (m_win == 0 || x > m_rm) ? x : m_rm;
        close = (m_win == N - 1) || (m_in == L - 1);
        if (close) begin
            e.data = m_rm;
            e.last = (m_in == L - 1);
            e.cyc  = cyc;
            e.lat  = lat_en;
            sb.push_back(e);
            m_win = 0;
            m_in  = (m_in == L - 1) ? 0 : m_in + 1;
        end else begin
            m_win++;
            m_in++;
        end
    endtask

    task automatic send(input int x);
        bit ok = 0;
        s_data  = 8'(x);
        s_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) ok = 1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
        else model_accept(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb.size(), 0);
        check("drain_valid", int'(m_valid), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", int'(m_data), mon_e.data);
                check("out_last", int'(m_last), int'(mon_e.last));
                if (mon_e.lat) check("out_latency", cyc, mon_e.cyc);
            end
            n_out++;
            if (m_last) n_last++;
        end
    end

    always @(posedge clk) begin
        if (tog_en) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int o0, l0;
        reset    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        s_valid1 = 1'b0;
        s_data1  = '0;
        m_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(m_valid), 0);
        check("rst_data", int'(m_data), 0);
        check("rst_last", int'(m_last), 0);
        check("rst_ready", int'(s_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic vector with latency check.
        m_ready = 1'b1;
        l0 = n_last;
        o0 = n_out;
        lat_en = 1;
        send(3); send(7); send(-1); send(4); send(9);
        lat_en = 0;
        drain();
        check("basic_count", n_out - o0, 3);
        check("basic_lasts", n_last - l0, 1);

        // Negative values and ties.
        send(-5); send(-3); send(-8); send(-8); send(-128);
        drain();

        // Backpressure: FIFO fills, closing sample 5 stalls.
        m_ready = 1'b0;
        send(1); send(2); send(3); send(4);
        s_data  = 8'sd5;
        s_valid = 1'b1;
        @(negedge clk);
        check("bp_stall_ready", int'(s_ready), 0);
        check("bp_head_valid", int'(m_valid), 1);
        check("bp_head_data", int'(m_data), 2);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(5);
        drain();

        // Two vectors, random gaps and toggling backpressure.
        o0 = n_out;
        l0 = n_last;
        tog_en = 1;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(int'($urandom_range(0, 255)) - 128);
        end
        tog_en = 0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();
        check("rand_count", n_out - o0, 6);
        check("rand_lasts", n_last - l0, 2);

        // Reset mid-vector discards the queued output and the partial window.
        m_ready = 1'b0;
        send(6); send(2); send(9);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", int'(s_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        m_in  = 0;
        m_win = 0;
        @(negedge clk);
        check("midrst_valid", int'(m_valid), 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        o0 = n_out;
        for (int i = 0; i < 5; i++) send(1);
        drain();
        check("midrst_count", n_out - o0, 3);

        // WIN=1 instance passes samples straight through.
        for (int i = 0; i < 10; i++) begin
            int v;
            v        = (i * 37) % 256 - 128;
            s_data1  = 8'(v);
            s_valid1 = 1'b1;
            @(negedge clk);
            check("w1_ready", int'(s_ready1), 1);
            @(posedge clk);
            #1;
            check("w1_valid", int'(m_valid1), 1);
            check("w1_data", int'(m_data1), v);
            check("w1_last", int'(m_last1), (i % L == L - 1) ? 1 : 0);
        end
        s_valid1 = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
